// File: rtl/bcd_pkg.sv
// bcd_pkg: shared FSM states, seven-segment glyph constants and digit-select indices
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [1:0] SEL_UNITS = 2'd0;
  localparam logic [1:0] SEL_TENS  = 2'd1;
  localparam logic [1:0] SEL_HUND  = 2'd2;
  localparam logic [1:0] SEL_SIGN  = 2'd3;
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD digit plus blank flag to active-low gfedcba segments
module seg7_decode
  import bcd_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  output logic [6:0] o_seg
);
  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank)
      case (i_digit)
        4'd0: o_seg = SEG_ZERO;
        4'd1: o_seg = 7'b1111001;
        4'd2: o_seg = 7'b0100100;
        4'd3: o_seg = 7'b0110000;
        4'd4: o_seg = 7'b0011001;
        4'd5: o_seg = 7'b0010010;
        4'd6: o_seg = 7'b0000010;
        4'd7: o_seg = 7'b1111000;
        4'd8: o_seg = 7'b0000000;
        4'd9: o_seg = 7'b0010000;
        default: o_seg = SEG_BLANK;
      endcase
  end
endmodule

// File: rtl/bcd_display_ctrl.sv
// bcd_display_ctrl: 8-bit value to sign + 3 BCD digits by double-dabble, scanned onto a 4-digit display
module bcd_display_ctrl
  import bcd_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] value,
  input  logic       is_signed,
  output logic       busy,
  output logic       done,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       neg,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);
  localparam int CW = $clog2(REFRESH_DIV);
  state_t r_state, w_next;
  logic [7:0] r_val, r_mag, w_mag;
  logic r_sgn, r_pneg, r_neg;
  logic [11:0] r_acc, w_adj, w_acc_next;
  logic [2:0] r_cnt;
  logic [3:0] r_hund, r_tens, r_units, r_an, w_digit;
  logic [CW-1:0] r_rcnt;
  logic [1:0] r_sel, w_sel;
  logic [6:0] r_seg, w_glyph, w_seg;
  logic w_wrap, w_blank;
  assign w_mag = (r_sgn & r_val[7]) ? -r_val : r_val;
  assign w_adj = {add3(r_acc[11:8]), add3(r_acc[7:4]), add3(r_acc[3:0])};
  assign w_acc_next = {w_adj[10:0], r_mag[7]};
  always_ff @(posedge clk)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state == IDLE  ? (start ? LOAD : IDLE) :
             r_state == LOAD  ? SHIFT :
             r_state == SHIFT ? (r_cnt == 3'd7 ? DONE : SHIFT) : IDLE;
    busy = r_state != IDLE;
    done = r_state == DONE;
  end
  // Digits are latched on the edge entering DONE so they are visible in the same cycle as done.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_val <= '0;
      r_sgn <= 1'b0;
      r_mag <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_pneg <= 1'b0;
      {r_hund, r_tens, r_units} <= '0;
      r_neg <= 1'b0;
    end else begin
      if (r_state == IDLE && start) begin
        r_val <= value;
        r_sgn <= is_signed;
      end
      if (r_state == LOAD) begin
        r_mag <= w_mag;
        r_pneg <= r_sgn & r_val[7];
        r_acc <= '0;
        r_cnt <= '0;
      end
      if (r_state == SHIFT) begin
        r_acc <= w_acc_next;
        r_mag <= {r_mag[6:0], 1'b0};
        r_cnt <= r_cnt + 3'd1;
        if (r_cnt == 3'd7) begin
          {r_hund, r_tens, r_units} <= w_acc_next;
          r_neg <= r_pneg;
        end
      end
    end
  end
  // Glyph and anode are both computed for the digit selected after this edge, so they switch together.
  assign w_wrap = r_rcnt == CW'(REFRESH_DIV - 1);
  assign w_sel = r_sel + {1'b0, w_wrap};
  assign w_digit = w_sel == SEL_UNITS ? r_units : w_sel == SEL_TENS ? r_tens : r_hund;
  assign w_blank = w_sel == SEL_TENS ? (r_hund == 4'd0 && r_tens == 4'd0) :
                   w_sel == SEL_HUND ? (r_hund == 4'd0) : w_sel == SEL_SIGN;
  assign w_seg = w_sel == SEL_SIGN ? (r_neg ? SEG_MINUS : SEG_BLANK) : w_glyph;
  seg7_decode u_dec (.i_digit(w_digit), .i_blank(w_blank), .o_seg(w_glyph));
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rcnt <= '0;
      r_sel <= SEL_UNITS;
      r_an <= 4'b1110;
      r_seg <= SEG_ZERO;
    end else begin
      r_rcnt <= w_wrap ? '0 : r_rcnt + CW'(1);
      r_sel <= w_sel;
      r_an <= ~(4'b0001 << w_sel);
      r_seg <= w_seg;
    end
  end
  assign hundreds = r_hund;
  assign tens = r_tens;
  assign units = r_units;
  assign neg = r_neg;
  assign an = r_an;
  assign seg = r_seg;
  assign dp = 1'b1;
endmodule

// File: tb/tb_bcd_display_ctrl.sv
// tb_bcd_display_ctrl: arithmetic reference model compared every cycle, plus directed literal checks
module tb_bcd_display_ctrl;
  localparam int DIV = 4;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] MINUS = 7'b0111111;
  localparam logic [6:0] ZERO = 7'b1000000;
  logic clk = 0, reset = 1, start = 0, is_signed = 0;
  logic [7:0] value = 0;
  logic busy, done, neg, dp;
  logic [3:0] hundreds, tens, units, an;
  logic [6:0] seg;
  int checks = 0, errors = 0;
  bcd_display_ctrl #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .start(start), .value(value), .is_signed(is_signed),
    .busy(busy), .done(done), .hundreds(hundreds), .tens(tens), .units(units),
    .neg(neg), .an(an), .seg(seg), .dp(dp)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [6:0] glyph_digit(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return BLANK;
    endcase
  endfunction
  function automatic logic [6:0] glyph(input int s, input int h, input int t, input int u, input bit n);
    if (s == 0) return glyph_digit(u);
    if (s == 1) return (h == 0 && t == 0) ? BLANK : glyph_digit(t);
    if (s == 2) return (h == 0) ? BLANK : glyph_digit(h);
    return n ? MINUS : BLANK;
  endfunction
  function automatic int nsel(input int s, input int rc);
    return (rc == DIV - 1) ? (s + 1) % 4 : s;
  endfunction
  function automatic logic [3:0] an_of(input int s);
    logic [3:0] a;
    a = 4'b1111;
    a[s] = 1'b0;
    return a;
  endfunction
  function automatic int mag_of(input logic [7:0] v, input bit s);
    return (s && v[7]) ? 256 - int'(v) : int'(v);
  endfunction
  bit m_ok = 0, m_n = 0, m_s = 0;
  int m_ph = 0, m_rc = 0, m_sel = 0, m_h = 0, m_t = 0, m_u = 0;
  logic [7:0] m_v = 0;
  logic [3:0] m_an = 4'b1110;
  logic [6:0] m_seg = ZERO;
  // m_ph counts cycles since an accepted start: 0 idle, 10 is the done cycle.
  always @(posedge clk) begin
    if (reset) begin
      m_ok <= 1;
      m_ph <= 0;
      m_rc <= 0;
      m_sel <= 0;
      m_h <= 0;
      m_t <= 0;
      m_u <= 0;
      m_n <= 0;
      m_an <= 4'b1110;
      m_seg <= ZERO;
    end else begin
      m_rc <= (m_rc == DIV - 1) ? 0 : m_rc + 1;
      m_sel <= nsel(m_sel, m_rc);
      m_an <= an_of(nsel(m_sel, m_rc));
      m_seg <= glyph(nsel(m_sel, m_rc), m_h, m_t, m_u, m_n);
      if (m_ph == 0) begin
        if (start) begin
          m_v <= value;
          m_s <= is_signed;
          m_ph <= 1;
        end
      end else begin
        m_ph <= (m_ph == 10) ? 0 : m_ph + 1;
        if (m_ph == 9) begin
          m_h <= mag_of(m_v, m_s) / 100;
          m_t <= (mag_of(m_v, m_s) / 10) % 10;
          m_u <= mag_of(m_v, m_s) % 10;
          m_n <= m_s && m_v[7];
        end
      end
    end
  end
  always @(negedge clk)
    if (m_ok) begin
      chk("busy", int'(busy), int'(m_ph != 0));
      chk("done", int'(done), int'(m_ph == 10));
      chk("hundreds", int'(hundreds), m_h);
      chk("tens", int'(tens), m_t);
      chk("units", int'(units), m_u);
      chk("neg", int'(neg), int'(m_n));
      chk("an", int'(an), int'(m_an));
      chk("seg", int'(seg), int'(m_seg));
      chk("dp", int'(dp), 1);
    end
  task automatic launch(input logic [7:0] v, input bit s);
    @(negedge clk);
    start = 1;
    value = v;
    is_signed = s;
    @(negedge clk);
    start = 0;
    value = ~v;
    is_signed = ~s;
  endtask
  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic wait_an(input logic [3:0] p);
    int n = 0;
    while (an != p && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk("wait_an", int'(an), int'(p));
  endtask
  task automatic count_done(input int cyc, output int cnt);
    cnt = 0;
    for (int i = 0; i < cyc; i++) begin
      if (done) cnt++;
      @(negedge clk);
    end
  endtask
  initial begin
    int n;
    int cnt;
    logic [3:0] pat [4];
    pat = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    repeat (2) @(negedge clk);
    chk("rst_an", int'(an), 4'b1110);
    chk("rst_seg", int'(seg), int'(ZERO));
    chk("rst_busy", int'(busy), 0);
    reset = 0;
    launch(8'd255, 0);
    wait_done(n);
    chk("lat255", n, 10);
    chk("h255", int'(hundreds), 2);
    chk("t255", int'(tens), 5);
    chk("u255", int'(units), 5);
    chk("n255", int'(neg), 0);
    @(negedge clk);
    chk("busy_after", int'(busy), 0);
    launch(8'h80, 1);
    wait_done(n);
    chk("lat80", n, 10);
    chk("h80", int'(hundreds), 1);
    chk("t80", int'(tens), 2);
    chk("u80", int'(units), 8);
    chk("n80", int'(neg), 1);
    @(negedge clk);
    wait_an(4'b0111);
    chk("minus", int'(seg), int'(MINUS));
    launch(8'd0, 0);
    wait_done(n);
    @(negedge clk);
    wait_an(4'b0111);
    while (an == 4'b0111 && n < 40) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 16; k++) begin
      chk("scan_an", int'(an), int'(pat[k / 4]));
      chk("scan_seg", int'(seg), int'((k / 4 == 0) ? ZERO : BLANK));
      @(negedge clk);
    end
    launch(8'd7, 0);
    @(negedge clk);
    @(negedge clk);
    start = 1;
    value = 8'd99;
    @(negedge clk);
    start = 0;
    count_done(20, cnt);
    chk("one_done", cnt, 1);
    chk("h7", int'(hundreds), 0);
    chk("t7", int'(tens), 0);
    chk("u7", int'(units), 7);
    launch(8'd200, 0);
    repeat (4) @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("mid_busy", int'(busy), 0);
    chk("mid_units", int'(units), 0);
    chk("mid_an", int'(an), 4'b1110);
    chk("mid_seg", int'(seg), int'(ZERO));
    reset = 0;
    count_done(15, cnt);
    chk("no_done", cnt, 0);
    chk("mid_h", int'(hundreds), 0);
    @(negedge clk);
    reset = 1;
    start = 1;
    value = 8'd5;
    @(negedge clk);
    reset = 0;
    start = 0;
    chk("rs_busy0", int'(busy), 0);
    @(negedge clk);
    chk("rs_busy1", int'(busy), 0);
    launch(8'h2A, 1);
    wait_done(n);
    chk("lat2a", n, 10);
    chk("h2a", int'(hundreds), 0);
    chk("t2a", int'(tens), 4);
    chk("u2a", int'(units), 2);
    chk("n2a", int'(neg), 0);
    @(negedge clk);
    wait_an(4'b1011);
    chk("hund_blank", int'(seg), int'(BLANK));
    wait_an(4'b1101);
    chk("tens_4", int'(seg), 7'b0011001);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd_display_ctrl.md
# bcd_display_ctrl

Sequential controller that converts an 8-bit ALU result (unsigned or two's-complement) to three BCD digits plus a sign flag. It uses an iterative shift-add-3 (double-dabble) datapath under a start/busy/done handshake. The latched digits are time-multiplexed onto the board's 4-digit active-low seven-segment display. The block sits between the ALU output and the display pins, replacing direct per-digit combinational conversion.

## Interface
- REFRESH_DIV, 100000, clock cycles each digit is lit (100 MHz clock → 1 kHz digit rate); must be ≥ 2
- clk  in  1  system clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  conversion request; sampled only in IDLE
- value  in  8  ALU result to convert; captured on the accepted start
- is_signed  in  1  1: treat value as two's complement; captured with value
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when new digits become visible
- hundreds, tens, units  out  4 each  latched BCD digits, 0–9 each
- neg  out  1  latched sign; 1 only for a negative signed input
- an  out  4  digit anodes, active-low; an[0]=units, an[1]=tens, an[2]=hundreds, an[3]=sign
- seg  out  7  segments, active-low, seg[6:0]=g,f,e,d,c,b,a
- dp  out  1  decimal point, constantly 1 (off)

## Operation
- FSM states: IDLE → LOAD → SHIFT → DONE → IDLE.
- IDLE: if start=1, capture value and is_signed, then go to LOAD.
- LOAD:
  - mag = (is_signed & value[7]) ? −value : value, computed 8-bit and treated as unsigned, so 8'h80 gives 128.
  - Record the pending sign, clear the 12-bit BCD accumulator, set the shift count to 0.
- SHIFT, one iteration per cycle for exactly 8 cycles:
  - Add 3 to each accumulator nibble that is ≥ 5.
  - Shift {accumulator, mag} left by one, moving the mag MSB into the accumulator LSB.
  - After the 8th shift, go to DONE.
- DONE:
  - Copy the accumulator into hundreds/tens/units and the pending sign into neg.
  - Pulse done and return to IDLE.
- start while busy is ignored, not queued. value and is_signed changing after capture have no effect.
- Outputs hundreds/tens/units/neg change only in DONE; the old values stay displayed throughout a conversion.
- Scanner, free-running and independent of the FSM:
  - The refresh counter counts 0..REFRESH_DIV−1 and wraps.
  - On wrap, the 2-bit digit select increments, wrapping 3→0.
  - an is one-hot-low for the selected digit.
- Digit glyphs:
  - Units digit: always its value.
  - Tens digit: blank if hundreds=0 and tens=0.
  - Hundreds digit: blank if hundreds=0.
  - Sign digit: '−' (7'b0111111) if neg=1, else blank (7'b1111111).
  - '0' is 7'b1000000.

## Timing
- start sampled high in IDLE at edge T:
  - busy=1 from T+1.
  - LOAD during T+1; SHIFT during T+2..T+9; DONE during T+10.
  - done=1 and new digits visible during T+10; busy=0 and ready for start from T+11.
- Fixed latency of 10 cycles from accepted start to done, independent of value.
- Reset, applied in any state including mid-SHIFT, takes effect at the next edge:
  - state=IDLE, busy=0, done=0, digits=0, neg=0, refresh counter=0, digit select=0.
  - an=4'b1110, seg=7'b1000000, dp=1.
  - Any in-flight conversion is discarded.
- start and reset high in the same cycle: reset wins.
- an and seg are registered and switch together on the wrap edge, with no mixed-digit cycle.

## Structure
- Package bcd_pkg holds:
  - the state enum (IDLE, LOAD, SHIFT, DONE);
  - segment constants SEG_BLANK, SEG_MINUS, SEG_ZERO;
  - digit-select index constants.
- Sub-module seg7_decode (combinational: 4-bit digit plus blank flag → 7-bit active-low seg) instantiated once on the muxed digit.
- FSM, double-dabble datapath and scanner live in bcd_display_ctrl.

## Test plan
- Unsigned 255: value=8'd255, is_signed=0, start 1 cycle → done exactly 10 cycles later; digits 2/5/5, neg=0, busy low the following cycle.
- Signed minimum: value=8'h80, is_signed=1 → digits 1/2/8, neg=1; sign anode shows seg=7'b0111111.
- Zero and blanking: value=0, REFRESH_DIV=4 → units shows 7'b1000000; tens, hundreds and sign show 7'b1111111; an cycles 1110→1101→1011→0111 every 4 cycles, then wraps.
- Busy rejection: start with value=8'd7, then start with value=8'd99 three cycles later → only 7 appears, one done pulse.
- Reset mid-conversion: reset asserted during the 4th SHIFT cycle → next cycle IDLE, busy=0, digits 0, an=4'b1110, no done pulse.
- Signed positive: value=8'h2A, is_signed=1 → digits 0/4/2, neg=0; hundreds blank, tens shows '4'.
